// File: rtl/energy_sample_aggregator.sv
// Multi-channel windowed mean/peak aggregator with threshold alarm and a
// global saturating energy accumulator; one result register with valid/ready.
module energy_sample_aggregator #(
   parameter int DATA_W   = 8,
   parameter int NUM_CH   = 4,
   parameter int AVG_LOG2 = 3,
   parameter int ENERGY_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          sample_in,
   input  logic [$clog2(NUM_CH)-1:0]  sample_ch,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   input  logic                       mode,
   input  logic [DATA_W-1:0]          threshold,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(NUM_CH)-1:0]  out_ch,
   output logic                       out_alarm,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       clear_energy,
   output logic [ENERGY_W-1:0]        energy_total,
   output logic                       energy_sat,
   output logic                       ch_err
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int SUM_W = DATA_W + AVG_LOG2;
   localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

   typedef enum logic {S_EMPTY, S_FULL} out_state_t;

   out_state_t            r_state, w_state_nxt;
   logic [SUM_W-1:0]      r_sum [NUM_CH];
   logic [DATA_W-1:0]     r_max [NUM_CH];
   logic [AVG_LOG2-1:0]   r_cnt [NUM_CH];
   logic [NUM_CH-1:0]     r_mode;
   logic [DATA_W-1:0]     r_out_data;
   logic [CH_W-1:0]       r_out_ch;
   logic                  r_out_alarm;
   logic [ENERGY_W-1:0]   r_energy;
   logic                  r_sat;
   logic                  r_err;

   logic                  w_ready, w_accept, w_tag_ok, w_first, w_last;
   logic [CH_W-1:0]       w_idx;
   logic [SUM_W-1:0]      w_sum_nxt;
   logic [DATA_W-1:0]     w_max_nxt, w_result;
   logic [ENERGY_W:0]     w_e_sum;

   assign w_ready  = !rst && !(r_state == S_FULL && !out_ready);
   assign w_accept = sample_valid && w_ready;
   assign w_tag_ok = {1'b0, sample_ch} < NUM_CH_L;

   // Out-of-range tags are steered to channel 0 for reads only; they never write channel state.
   always_comb begin
      w_idx     = w_tag_ok ? sample_ch : '0;
      w_first   = (r_cnt[w_idx] == '0);
      w_sum_nxt = r_sum[w_idx] + SUM_W'(sample_in);
      w_max_nxt = (sample_in > r_max[w_idx]) ? sample_in : r_max[w_idx];
      w_last    = w_accept && w_tag_ok && (r_cnt[w_idx] == '1);
      w_result  = r_mode[w_idx] ? w_max_nxt : w_sum_nxt[SUM_W-1:AVG_LOG2];
      w_e_sum   = {1'b0, r_energy} + (ENERGY_W+1)'(sample_in);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_last) w_state_nxt = S_FULL;
         S_FULL: begin
            if (w_last)         w_state_nxt = S_FULL;
            else if (out_ready) w_state_nxt = S_EMPTY;
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            r_sum[i] <= '0;
            r_max[i] <= '0;
            r_cnt[i] <= '0;
         end
         r_mode      <= '0;
         r_state     <= S_EMPTY;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_alarm <= 1'b0;
         r_energy    <= '0;
         r_sat       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept && w_tag_ok) begin
            r_cnt[w_idx] <= r_cnt[w_idx] + 1'b1;
            if (w_first) begin
               r_mode[w_idx] <= mode;
               r_sum[w_idx]  <= SUM_W'(sample_in);
               r_max[w_idx]  <= sample_in;
            end else begin
               r_sum[w_idx]  <= w_sum_nxt;
               r_max[w_idx]  <= w_max_nxt;
            end
         end
         if (w_accept && !w_tag_ok) r_err <= 1'b1;
         if (w_last) begin
            r_out_data  <= w_result;
            r_out_ch    <= sample_ch;
            r_out_alarm <= (w_result > threshold);
         end
         // Clear wins over a same-edge accept: that sample is not counted.
         if (clear_energy) begin
            r_energy <= '0;
            r_sat    <= 1'b0;
         end else if (w_accept) begin
            if (w_e_sum[ENERGY_W]) begin
               r_energy <= '1;
               r_sat    <= 1'b1;
            end else begin
               r_energy <= w_e_sum[ENERGY_W-1:0];
            end
         end
      end
   end

   assign sample_ready = w_ready;
   assign out_valid    = (r_state == S_FULL);
   assign out_data     = r_out_data;
   assign out_ch       = r_out_ch;
   assign out_alarm    = r_out_alarm;
   assign energy_total = r_energy;
   assign energy_sat   = r_sat;
   assign ch_err       = r_err;

endmodule

// File: tb/tb_energy_sample_aggregator.sv
// Bench: default-parameter instance checked against a window-buffer model,
// plus a NUM_CH=3 / ENERGY_W=12 instance for saturation and bad-tag cases.
module tb_energy_sample_aggregator;

   logic       clk;
   logic       rst;
   logic [7:0] sample_in;
   logic [1:0] sample_ch;
   logic       sample_valid;
   logic       mode;
   logic [7:0] threshold;
   logic       out_ready;
   logic       clear_energy;

   logic        a_ready, a_al, a_ov, a_sat, a_err;
   logic [7:0]  a_od;
   logic [1:0]  a_och;
   logic [31:0] a_et;

   logic        b_ready, b_al, b_ov, b_sat, b_err;
   logic [7:0]  b_od;
   logic [1:0]  b_och;
   logic [11:0] b_et;

   energy_sample_aggregator #(.DATA_W(8), .NUM_CH(4), .AVG_LOG2(3), .ENERGY_W(32)) dut_a (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_ch(sample_ch),
      .sample_valid(sample_valid), .sample_ready(a_ready), .mode(mode),
      .threshold(threshold), .out_data(a_od), .out_ch(a_och), .out_alarm(a_al),
      .out_valid(a_ov), .out_ready(out_ready), .clear_energy(clear_energy),
      .energy_total(a_et), .energy_sat(a_sat), .ch_err(a_err)
   );

   energy_sample_aggregator #(.DATA_W(8), .NUM_CH(3), .AVG_LOG2(3), .ENERGY_W(12)) dut_b (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_ch(sample_ch),
      .sample_valid(sample_valid), .sample_ready(b_ready), .mode(mode),
      .threshold(threshold), .out_data(b_od), .out_ch(b_och), .out_alarm(b_al),
      .out_valid(b_ov), .out_ready(out_ready), .clear_energy(clear_energy),
      .energy_total(b_et), .energy_sat(b_sat), .ch_err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model for dut_a: stores each window's samples, reduces at window end.
   int     m_win [4][8];
   int     m_n   [4];
   bit     m_mode[4];
   bit     m_ov, m_oal, m_sat, m_err;
   int     m_od, m_och;
   longint m_e;
   localparam longint EMAX = (longint'(1) << 32) - 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_n[c] = 0;
         m_mode[c] = 0;
      end
      m_ov = 0; m_oal = 0; m_od = 0; m_och = 0;
      m_e = 0; m_sat = 0; m_err = 0;
   endtask

   task automatic model_edge(output bit acc);
      bit comp;
      int res;
      acc = 0;
      comp = 0;
      res = 0;
      if (rst) begin
         model_reset();
         return;
      end
      acc = sample_valid && !(m_ov && !out_ready);
      if (acc) begin
         int c;
         c = int'(sample_ch);
         if (m_n[c] == 0) m_mode[c] = mode;
         m_win[c][m_n[c]] = int'(sample_in);
         m_n[c]++;
         if (m_n[c] == 8) begin
            int s;
            int mx;
            s = 0;
            mx = 0;
            for (int k = 0; k < 8; k++) begin
               s += m_win[c][k];
               if (m_win[c][k] > mx) mx = m_win[c][k];
            end
            res = m_mode[c] ? mx : s / 8;
            comp = 1;
            m_n[c] = 0;
            m_och = c;
         end
      end
      if (clear_energy) begin
         m_e = 0;
         m_sat = 0;
      end else if (acc) begin
         m_e += longint'(sample_in);
         if (m_e > EMAX) begin
            m_e = EMAX;
            m_sat = 1;
         end
      end
      if (comp) begin
         m_ov = 1;
         m_od = res;
         m_oal = (res > int'(threshold));
      end else if (m_ov && out_ready) begin
         m_ov = 0;
      end
   endtask

   task automatic tick(output bit acc);
      #1;
      chk("sample_ready", longint'(a_ready), longint'(!rst && !(m_ov && !out_ready)));
      @(posedge clk);
      model_edge(acc);
      #1;
      chk("out_valid", longint'(a_ov), longint'(m_ov));
      chk("out_data", longint'(a_od), longint'(m_od));
      chk("out_ch", longint'(a_och), longint'(m_och));
      chk("out_alarm", longint'(a_al), longint'(m_oal));
      chk("energy_total", longint'(a_et), m_e);
      chk("energy_sat", longint'(a_sat), longint'(m_sat));
      chk("ch_err", longint'(a_err), longint'(m_err));
   endtask

   task automatic send(input int ch, input int s);
      bit acc;
      int n;
      sample_valid = 1;
      sample_ch = 2'(ch);
      sample_in = 8'(s);
      acc = 0;
      n = 0;
      while (!acc && n < 20) begin
         tick(acc);
         n++;
      end
      chk("send_accept", longint'(acc), 1);
      sample_valid = 0;
   endtask

   typedef struct {
      logic [1:0] ch;
      logic [7:0] s;
      logic       md;
      logic       ev;
      logic [7:0] ed;
      logic [1:0] ech;
      logic       eal;
   } vec_t;

   vec_t tbl[32];
   int   peak_seq[8] = '{45, 200, 10, 0, 0, 0, 0, 0};

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;

      for (int i = 0; i < 32; i++) begin
         tbl[i].ev = 0; tbl[i].ed = 0; tbl[i].ech = 0; tbl[i].eal = 0; tbl[i].md = 0;
         if (i < 8) begin
            tbl[i].ch = 0; tbl[i].s = 150;
            if (i == 7) begin tbl[i].ev = 1; tbl[i].ed = 150; tbl[i].ech = 0; tbl[i].eal = 1; end
         end else if (i < 16) begin
            tbl[i].ch = 1; tbl[i].s = 8'(i - 8);
            if (i == 15) begin tbl[i].ev = 1; tbl[i].ed = 3; tbl[i].ech = 1; tbl[i].eal = 0; end
         end else if (i < 24) begin
            tbl[i].ch = 2; tbl[i].s = 8'(peak_seq[i-16]); tbl[i].md = (i - 16 < 2);
            if (i == 23) begin tbl[i].ev = 1; tbl[i].ed = 200; tbl[i].ech = 2; tbl[i].eal = 1; end
         end else begin
            tbl[i].ch = 2; tbl[i].s = 16;
            if (i == 31) begin tbl[i].ev = 1; tbl[i].ed = 16; tbl[i].ech = 2; tbl[i].eal = 0; end
         end
      end

      model_reset();
      rst = 1; sample_valid = 1; sample_in = 8'd99; sample_ch = 0; mode = 0;
      threshold = 8'd100; out_ready = 1; clear_energy = 0;

      // Reset held two cycles with a sample offered
      repeat (2) begin
         #1;
         chk("rst_ready_low", longint'(a_ready), 0);
         tick(acc);
      end
      chk("rst_out_valid", longint'(a_ov), 0);
      chk("rst_energy", longint'(a_et), 0);
      rst = 0; sample_valid = 0;
      #1;
      chk("post_rst_ready", longint'(a_ready), 1);

      // Mean / peak windows, mode change mid-window
      for (int i = 0; i < 32; i++) begin
         sample_valid = 1;
         sample_ch = tbl[i].ch;
         sample_in = tbl[i].s;
         mode = tbl[i].md;
         tick(acc);
         chk("tbl_accept", longint'(acc), 1);
         chk("tbl_valid", longint'(a_ov), longint'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk("tbl_data", longint'(a_od), longint'(tbl[i].ed));
            chk("tbl_ch", longint'(a_och), longint'(tbl[i].ech));
            chk("tbl_alarm", longint'(a_al), longint'(tbl[i].eal));
         end
      end
      sample_valid = 0;
      mode = 0;
      tick(acc);

      // Interleave ch0/ch3 under backpressure
      rst = 1; tick(acc); rst = 0;
      out_ready = 0;
      for (int i = 0; i < 15; i++) send((i % 2) ? 3 : 0, (i % 2) ? 20 : 10);
      chk("bp_first_valid", longint'(a_ov), 1);
      chk("bp_first_data", longint'(a_od), 10);
      chk("bp_first_ch", longint'(a_och), 0);
      sample_valid = 1; sample_ch = 3; sample_in = 20;
      repeat (5) begin
         #1;
         chk("bp_ready_low", longint'(a_ready), 0);
         tick(acc);
         chk("bp_no_accept", longint'(acc), 0);
         chk("bp_hold_data", longint'(a_od), 10);
         chk("bp_hold_ch", longint'(a_och), 0);
         chk("bp_hold_valid", longint'(a_ov), 1);
      end
      out_ready = 1;
      tick(acc);
      chk("bp_release_accept", longint'(acc), 1);
      chk("bp_second_valid", longint'(a_ov), 1);
      chk("bp_second_data", longint'(a_od), 20);
      chk("bp_second_ch", longint'(a_och), 3);
      chk("bp_energy", longint'(a_et), 240);
      sample_valid = 0;
      tick(acc);
      chk("bp_drain", longint'(a_ov), 0);

      // Saturation on the 12-bit accumulator, then clear against an accept
      rst = 1; tick(acc); rst = 0;
      sample_valid = 1; sample_ch = 0; sample_in = 8'd255;
      repeat (16) tick(acc);
      chk("sat_before_et", longint'(b_et), 4080);
      chk("sat_before_flag", longint'(b_sat), 0);
      tick(acc);
      chk("sat_et", longint'(b_et), 4095);
      chk("sat_flag", longint'(b_sat), 1);
      tick(acc);
      chk("sat_hold_et", longint'(b_et), 4095);
      clear_energy = 1;
      tick(acc);
      chk("clr_et", longint'(b_et), 0);
      chk("clr_sat", longint'(b_sat), 0);
      clear_energy = 0; sample_valid = 0;

      // Out-of-range tag on the 3-channel instance
      rst = 1; tick(acc); rst = 0;
      sample_valid = 1; sample_ch = 3; sample_in = 8'd50;
      tick(acc);
      sample_valid = 0;
      tick(acc);
      chk("badtag_err", longint'(b_err), 1);
      chk("badtag_no_valid", longint'(b_ov), 0);
      chk("badtag_energy", longint'(b_et), 50);
      rst = 1; tick(acc); rst = 0;
      chk("badtag_rst_clears", longint'(b_err), 0);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 299) == 0);
         sample_valid = ($urandom_range(0, 9) < 7);
         sample_ch    = 2'($urandom);
         sample_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
         mode         = 1'($urandom);
         threshold    = 8'($urandom);
         out_ready    = ($urandom_range(0, 9) < 6);
         clear_energy = ($urandom_range(0, 49) == 0);
         tick(acc);
      end

      rst = 0; sample_valid = 0; clear_energy = 0; out_ready = 1;
      tick(acc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
